// File: rtl/vm_brew_sequencer.sv
// ---------------------------------------------------------------------------
// vm_brew_sequencer
// Sequences one cup of coffee after the vending FSM has accepted payment:
// CHECK supplies, GRIND, HEAT (bounded wait for temperature), POUR, DONE.
// One extra request can be queued while a cup is in progress.  Supply or
// heater problems latch a FAULT state until the operator clears it with
// supplies restored.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous, active-high reset
//   brew_req_i   1-cycle pulse, one paid cup requested
//   water_lvl_i  tank level 0..31
//   beans_ok_i   bean hopper not empty
//   temp_ok_i    heater at brew temperature
//   fault_clr_i  operator acknowledge (level)
//   grind_en_o   grinder motor on
//   heat_en_o    heater on
//   pump_en_o    water pump on
//   busy_o       sequencer is working on a cup (not IDLE, not FAULT)
//   done_o       1-cycle pulse, cup finished
//   fault_o      high while in FAULT
//   drop_o       1-cycle pulse, a request was discarded
//   cups_o       completed-cup count, saturating
// ---------------------------------------------------------------------------
module vm_brew_sequencer #(
  parameter int unsigned GRIND_CYC     = 4,
  parameter int unsigned HEAT_TMO      = 20,
  parameter int unsigned POUR_CYC      = 6,
  parameter int unsigned WATER_PER_CUP = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        brew_req_i,
  input  logic [4:0]  water_lvl_i,
  input  logic        beans_ok_i,
  input  logic        temp_ok_i,
  input  logic        fault_clr_i,
  output logic        grind_en_o,
  output logic        heat_en_o,
  output logic        pump_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic        drop_o,
  output logic [15:0] cups_o
);

  // Timer only ever holds a phase length minus one.
  localparam int unsigned TMAX_GH = (GRIND_CYC > HEAT_TMO) ? GRIND_CYC : HEAT_TMO;
  localparam int unsigned TMAX    = (TMAX_GH > POUR_CYC) ? TMAX_GH : POUR_CYC;
  localparam int unsigned TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_GRIND = 3'd2,
    ST_HEAT  = 3'd3,
    ST_POUR  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pend_q, pend_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;
  logic [15:0]     cups_q, cups_d;

  logic            supply_ok_s;
  logic            timer_zero_s;
  logic            busy_s;
  logic            fault_entry_s;

  assign supply_ok_s   = (water_lvl_i >= 5'(WATER_PER_CUP)) && beans_ok_i;
  assign timer_zero_s  = (timer_q == {TW{1'b0}});
  assign fault_entry_s = (state_d == ST_FAULT) && (state_q != ST_FAULT);

  // State, timer, queue and pulse registers; reset aborts any cup at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      timer_q <= {TW{1'b0}};
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      cups_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      cups_q  <= cups_d;
    end
  end

  // Next-state and phase timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (brew_req_i || pend_q) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (supply_ok_s) begin
          state_d = ST_GRIND;
          timer_d = TW'(GRIND_CYC - 1);
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_GRIND: begin
        if (timer_zero_s) begin
          state_d = ST_HEAT;
          timer_d = TW'(HEAT_TMO - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_HEAT: begin
        // Reaching temperature wins over a timeout in the same cycle.
        if (temp_ok_i) begin
          state_d = ST_POUR;
          timer_d = TW'(POUR_CYC - 1);
        end else if (timer_zero_s) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_POUR: begin
        // A dry tank stops the pump regardless of the remaining pour time.
        if (water_lvl_i == 5'd0) begin
          state_d = ST_FAULT;
        end else if (timer_zero_s) begin
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr_i && supply_ok_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = {TW{1'b0}};
      end
    endcase
  end

  // Request queue, discard pulse, done pulse and cup counter.
  always_comb begin
    pend_d = pend_q;
    drop_d = 1'b0;
    if (fault_entry_s) begin
      // Both the queued and any same-cycle request are lost; one pulse covers both.
      pend_d = 1'b0;
      drop_d = brew_req_i | pend_q;
    end else if (state_q == ST_FAULT) begin
      pend_d = 1'b0;
      drop_d = brew_req_i;
    end else if (state_q == ST_IDLE) begin
      // The pending request is consumed now; a fresh one takes its slot.
      pend_d = pend_q & brew_req_i;
    end else if (busy_s && brew_req_i) begin
      if (pend_q) begin
        drop_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end else begin
      pend_d = pend_q;
    end

    done_d = (state_d == ST_DONE);

    if ((state_q == ST_DONE) && (cups_q != 16'hFFFF)) begin
      cups_d = cups_q + 16'd1;
    end else begin
      cups_d = cups_q;
    end
  end

  // Moore decode of actuators and status from the state register.
  always_comb begin
    grind_en_o = 1'b0;
    heat_en_o  = 1'b0;
    pump_en_o  = 1'b0;
    busy_s     = 1'b0;
    fault_o    = 1'b0;
    case (state_q)
      ST_IDLE:  begin
        busy_s = 1'b0;
      end
      ST_CHECK: begin
        busy_s = 1'b1;
      end
      ST_GRIND: begin
        busy_s     = 1'b1;
        grind_en_o = 1'b1;
      end
      ST_HEAT:  begin
        busy_s    = 1'b1;
        heat_en_o = 1'b1;
      end
      ST_POUR:  begin
        busy_s    = 1'b1;
        heat_en_o = 1'b1;
        pump_en_o = 1'b1;
      end
      ST_DONE:  begin
        busy_s = 1'b1;
      end
      ST_FAULT: begin
        fault_o = 1'b1;
      end
      default:  begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign busy_o = busy_s;
  assign done_o = done_q;
  assign drop_o = drop_q;
  assign cups_o = cups_q;

endmodule
